activation_lut_loader: RTL and testbench

Writer side of the activation-function lookup table. Accepts a stream of 16 signed 8-bit sample points over a valid/ready handshake, stores them in a 16-entry register file, and serves the read pair (base, next_data) that the activation interpolator consumes. Sits between the weight/parameter loader and each layer's activation function, so activation curves can be reloaded at run time instead of being fixed at synthesis.

---
 rtl/activation_lut_loader_if.sv | 22 ++
 rtl/activation_lut_loader.sv | 101 ++++++++++
 tb/tb_activation_lut_loader.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/activation_lut_loader_if.sv
// Write-stream bundle between the parameter loader (master) and the
// activation LUT writer (slave): load request, sample handshake and status.
interface activation_lut_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  load_busy;
    logic                  load_done;

    modport master (
        output start, wr_valid, wr_data,
        input  wr_ready, load_busy, load_done
    );

    modport slave (
        input  start, wr_valid, wr_data,
        output wr_ready, load_busy, load_done
    );
endinterface

// File: rtl/activation_lut_loader.sv
// Activation LUT writer: loads 16 signed samples over valid/ready into a
// register file and serves the (base, next_data) pair to the interpolator.
module activation_lut_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    activation_lut_loader_if.slave       wr_if,
    input  logic [ADDR_WIDTH-1:0]        i_address,
    output logic                         o_lut_valid,
    output logic signed [DATA_WIDTH-1:0] o_base,
    output logic signed [DATA_WIDTH-1:0] o_next_data
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    logic [ADDR_WIDTH-1:0]        r_cnt;
    logic                         r_wr_ready;
    logic                         r_load_busy;
    logic                         r_load_done;
    logic                         r_lut_valid;
    logic signed [DATA_WIDTH-1:0] r_entry [DEPTH];

    logic                         w_accept;
    logic [ADDR_WIDTH-1:0]        w_next_addr;

    // wr_ready is only ever high in LOAD, so it alone qualifies an accept
    assign w_accept = wr_if.wr_valid & r_wr_ready;

    // Load FSM with registered status outputs; entries persist across
    // reloads and are only cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_wr_ready  <= 1'b0;
            r_load_busy <= 1'b0;
            r_load_done <= 1'b0;
            r_lut_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entry[i] <= '0;
            end
        end else begin
            r_load_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (wr_if.start) begin
                        r_state     <= S_LOAD;
                        r_cnt       <= '0;
                        r_wr_ready  <= 1'b1;
                        r_load_busy <= 1'b1;
                        r_lut_valid <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // start is deliberately ignored here: a load never restarts
                    if (w_accept) begin
                        r_entry[r_cnt] <= wr_if.wr_data;
                        r_cnt          <= r_cnt + ADDR_WIDTH'(1);
                        if (r_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                            r_state     <= S_DONE;
                            r_wr_ready  <= 1'b0;
                            r_load_busy <= 1'b0;
                            r_load_done <= 1'b1;
                            r_lut_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wr_ready  <= 1'b0;
                    r_load_busy <= 1'b0;
                    r_lut_valid <= 1'b0;
                end
            endcase
        end
    end

    // Upper neighbour saturates at the last entry instead of wrapping to 0
    always_comb begin
        w_next_addr = i_address + ADDR_WIDTH'(1);
        if (i_address == ADDR_WIDTH'(DEPTH - 1)) begin
            w_next_addr = i_address;
        end
    end

    assign o_base      = r_entry[i_address];
    assign o_next_data = r_entry[w_next_addr];
    assign o_lut_valid = r_lut_valid;

    assign wr_if.wr_ready  = r_wr_ready;
    assign wr_if.load_busy = r_load_busy;
    assign wr_if.load_done = r_load_done;
endmodule

// File: tb/tb_activation_lut_loader.sv
// Bench for activation_lut_loader: directed load scenarios followed by
// random traffic, all compared cycle by cycle against a table-level model.
module tb_activation_lut_loader;
    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        address;
    logic              lut_valid;
    logic signed [7:0] base;
    logic signed [7:0] next_data;

    activation_lut_loader_if #(.DATA_WIDTH(8)) lif ();

    activation_lut_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_if       (lif),
        .i_address   (address),
        .o_lut_valid (lut_valid),
        .o_base      (base),
        .o_next_data (next_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    // Reference model: the table contents plus "how many samples still owed"
    logic signed [7:0] m_ent [16];
    bit                m_loading;
    bit                m_valid;
    bit                m_done;
    int                m_written;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_edge(input bit r, input bit st, input bit v,
                                       input logic signed [7:0] d);
        m_done = 0;
        if (r) begin
            foreach (m_ent[i]) m_ent[i] = 0;
            m_loading = 0;
            m_valid   = 0;
            m_written = 0;
        end else if (!m_loading) begin
            if (st) begin
                m_loading = 1;
                m_valid   = 0;
                m_written = 0;
            end
        end else if (v) begin
            m_ent[m_written] = d;
            m_written++;
            if (m_written == 16) begin
                m_loading = 0;
                m_valid   = 1;
                m_done    = 1;
            end
        end
    endfunction

    // One clock: drive inputs, let the edge happen, update model, compare
    task automatic cyc(input bit r, input bit st, input bit v,
                       input logic signed [7:0] d, input logic [3:0] a);
        int nx;
        rst          = r;
        lif.start    = st;
        lif.wr_valid = v;
        lif.wr_data  = d;
        address      = a;
        @(posedge clk);
        model_edge(r, st, v, d);
        #1;
        nx = (a == 4'd15) ? 15 : int'(a) + 1;
        if (lif.load_done === 1'b1) n_done++;
        chk("wr_ready",  int'(lif.wr_ready),  int'(m_loading));
        chk("load_busy", int'(lif.load_busy), int'(m_loading));
        chk("load_done", int'(lif.load_done), int'(m_done));
        chk("lut_valid", int'(lut_valid),     int'(m_valid));
        chk("base",      int'(base),          int'(m_ent[a]));
        chk("next_data", int'(next_data),     int'(m_ent[nx]));
    endtask

    task automatic idle(input logic [3:0] a);
        cyc(1'b0, 1'b0, 1'b0, 8'sd0, a);
    endtask

    function automatic logic [3:0] ra();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic signed [7:0] rd();
        return 8'($urandom);
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cycles;
        int d0;
        rst = 1'b1; lif.start = 0; lif.wr_valid = 0; lif.wr_data = 0; address = 0;

        // Reset: every address reads zero, nothing valid or ready
        cyc(1'b1, 1'b0, 1'b0, 8'sd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 8'sd0, 4'd0);
        for (int a = 0; a < 16; a++) idle(4'(a));

        // Back-to-back load of 8*i-64
        n_done = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'sd0, ra());
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 8'(8 * i - 64), ra());
        idle(4'd3);
        chk("ramp_base3", int'(base), -40);
        chk("ramp_next3", int'(next_data), -32);
        idle(4'd15);
        chk("ramp_base15", int'(base), 56);
        chk("ramp_next15", int'(next_data), 56);
        chk("ramp_done_pulses", n_done, 1);

        // Stalled load: wr_valid every other cycle, same contents, 32 cycles
        n_done = 0;
        cycles = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'sd0, ra());
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 1'b0, 1'b0, rd(), ra());
            cyc(1'b0, 1'b0, 1'b1, 8'(8 * i - 64), ra());
            cycles += 2;
        end
        chk("stall_cycles", cycles, 32);
        chk("stall_valid", int'(lut_valid), 1);
        chk("stall_done_pulses", n_done, 1);
        idle(4'd15);
        chk("stall_base15", int'(base), 56);

        // start at sample 7 is ignored; load finishes after 16 samples
        n_done = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'sd0, ra());
        for (int i = 0; i < 16; i++) cyc(1'b0, (i == 7), 1'b1, 8'(i + 1), ra());
        chk("restart_ignored_valid", int'(lut_valid), 1);
        chk("restart_done_pulses", n_done, 1);
        idle(4'd7);
        chk("restart_base7", int'(base), 8);

        // Reset after 5 samples aborts: zeroed table, no pulse, then reload
        n_done = 0;
        cyc(1'b0, 1'b1, 1'b0, 8'sd0, ra());
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, rd(), ra());
        cyc(1'b1, 1'b0, 1'b0, 8'sd0, 4'd0);
        for (int a = 0; a < 16; a++) idle(4'(a));
        chk("abort_done_pulses", n_done, 0);
        cyc(1'b0, 1'b1, 1'b0, 8'sd0, ra());
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, rd(), ra());
        chk("abort_reload_done", n_done, 1);

        // Reload from DONE with -i and occasional stalls; old entries linger
        cyc(1'b0, 1'b1, 1'b0, 8'sd0, ra());
        chk("reload_valid_low", int'(lut_valid), 0);
        d0 = 0;
        for (int guard = 0; guard < 64 && d0 < 16; guard++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, rd(), ra());
            else begin
                cyc(1'b0, 1'b0, 1'b1, 8'(-d0), ra());
                d0++;
            end
        end
        chk("reload_count", d0, 16);
        idle(4'd15);
        chk("neg_base15", int'(base), -15);
        chk("neg_next15", int'(next_data), -15);

        // Random traffic including stray wr_valid, start and rare resets
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 9) == 0),
                $urandom_range(0, 1) == 1, rd(), ra());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
